// File: rtl/rr_channel_merge.sv
// rr_channel_merge: merges DATA_DEPTH valid/ready input channels into one
// registered output stream. Arbitration is round-robin (ARB_MODE=0) or fixed
// lowest-index priority (ARB_MODE=1). The grant is one-hot and selects the
// winning word with an AND-OR mux, so there is no priority chain in the data path.
module rr_channel_merge #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DATA_DEPTH = 8,
  parameter  int ARB_MODE   = 0,
  localparam int ID_WIDTH   = $clog2(DATA_DEPTH)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DATA_WIDTH*DATA_DEPTH-1:0] data_in,
  input  logic [DATA_DEPTH-1:0]            valid_in,
  output logic [DATA_DEPTH-1:0]            ready_out,
  output logic [DATA_WIDTH-1:0]            data_out,
  output logic [ID_WIDTH-1:0]              id_out,
  output logic                             valid_out,
  input  logic                             ready_in
);

  // Constant 1 at the request-vector width, used for lowest-set-bit isolation.
  localparam logic [DATA_DEPTH-1:0] LSB_ONE  = DATA_DEPTH'(1);
  // After reset the pointer sits on the last channel so channel 0 is searched first.
  localparam logic [ID_WIDTH-1:0]   PTR_INIT = ID_WIDTH'(DATA_DEPTH - 1);

  // Output register and arbitration pointer.
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ID_WIDTH-1:0]   r_last_ptr;

  // Arbitration and datapath nets.
  logic                  w_load_en;
  logic                  w_any_req;
  logic                  w_xfer_in;
  logic [DATA_DEPTH-1:0] w_mask;
  logic [DATA_DEPTH-1:0] w_req_hi;
  logic [DATA_DEPTH-1:0] w_gnt_hi;
  logic [DATA_DEPTH-1:0] w_gnt_lo;
  logic [DATA_DEPTH-1:0] w_gnt;
  logic [ID_WIDTH-1:0]   w_gnt_id;
  logic [DATA_WIDTH-1:0] w_gnt_data;
  logic [DATA_WIDTH-1:0] w_word [DATA_DEPTH];

  // Per-channel search mask and gated word.
  // In round-robin mode the mask marks channels strictly above the last grant;
  // those are searched first, then the whole request vector wraps around from
  // channel 0 (which leaves last_ptr itself as the final candidate). In fixed
  // priority mode the mask is empty, so the plain lowest requester wins.
  for (genvar gi = 0; gi < DATA_DEPTH; gi++) begin : g_chan
    if (ARB_MODE == 0) begin : g_rr
      assign w_mask[gi] = (ID_WIDTH'(gi) > r_last_ptr);
    end else begin : g_fp
      assign w_mask[gi] = 1'b0;
    end
    assign w_word[gi] = data_in[gi*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{w_gnt[gi]}};
  end

  // Lowest-set-bit isolation, x & (~x + 1), gives a one-hot grant in both halves.
  assign w_req_hi = valid_in & w_mask;
  assign w_gnt_hi = w_req_hi & (~w_req_hi + LSB_ONE);
  assign w_gnt_lo = valid_in & (~valid_in + LSB_ONE);
  assign w_gnt    = (|w_req_hi) ? w_gnt_hi : w_gnt_lo;
  assign w_any_req = |valid_in;

  // The single output register can take a word when empty or when draining.
  assign w_load_en = ~r_valid | ready_in;

  // ready_out depends only on valid_in, the pointer, ready_in and the held
  // valid bit. It never depends on itself. It is forced low while reset is asserted.
  assign ready_out = w_gnt & {DATA_DEPTH{w_load_en & rst_n}};
  assign w_xfer_in = w_load_en & w_any_req & rst_n;

  // One-hot AND-OR mux of the granted word and its index.
  always_comb begin
    w_gnt_data = '0;
    w_gnt_id   = '0;
    for (int i = 0; i < DATA_DEPTH; i++) begin
      w_gnt_data = w_gnt_data | w_word[i];
      w_gnt_id   = w_gnt_id | (ID_WIDTH'(i) & {ID_WIDTH{w_gnt[i]}});
    end
  end

  // Output stage: load on an input transfer, clear valid on a bare drain, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_id    <= '0;
    end else if (w_xfer_in) begin
      r_valid <= 1'b1;
      r_data  <= w_gnt_data;
      r_id    <= w_gnt_id;
    end else if (w_load_en) begin
      r_valid <= 1'b0;
    end
  end

  // Round-robin pointer advances only when a word is actually accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_ptr <= PTR_INIT;
    end else if ((ARB_MODE == 0) && w_xfer_in) begin
      r_last_ptr <= w_gnt_id;
    end
  end

  assign valid_out = r_valid;
  assign data_out  = r_data;
  assign id_out    = r_id;

endmodule

// File: tb/tb_rr_channel_merge.sv
// Directed testbench for rr_channel_merge with 8 channels and 32-bit words.
// It runs a round-robin instance and a fixed-priority instance on shared inputs.
module tb_rr_channel_merge;
  localparam int DW = 32;
  localparam int DD = 8;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [DW*DD-1:0] data_in;
  logic [DD-1:0]   valid_in;
  logic            ready_in;

  logic [DD-1:0]   ready_out, fp_ready_out;
  logic [DW-1:0]   data_out, fp_data_out;
  logic [IW-1:0]   id_out, fp_id_out;
  logic            valid_out, fp_valid_out;

  int n_cmp = 0;
  int n_mis = 0;

  rr_channel_merge #(.DATA_WIDTH(DW), .DATA_DEPTH(DD), .ARB_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .data_out(data_out), .id_out(id_out),
    .valid_out(valid_out), .ready_in(ready_in)
  );

  rr_channel_merge #(.DATA_WIDTH(DW), .DATA_DEPTH(DD), .ARB_MODE(1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
    .ready_out(fp_ready_out), .data_out(fp_data_out), .id_out(fp_id_out),
    .valid_out(fp_valid_out), .ready_in(ready_in)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input int i);
    return 32'hCAFE_0000 | 32'(i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < DD; i++) data_in[i*DW +: DW] = word(i);
    valid_in = '0;
    ready_in = 1'b1;

    // Reset: outputs cleared, ready_out held low even with requests present.
    #1 rst_n = 1'b0;
    valid_in = 8'hFF;
    tick();
    tick();
    chk("rst_valid", 32'(valid_out), 32'h0);
    chk("rst_data", data_out, 32'h0);
    chk("rst_id", 32'(id_out), 32'h0);
    chk("rst_ready", 32'(ready_out), 32'h0);
    chk("rst_fp_ready", 32'(fp_ready_out), 32'h0);

    // All channels requesting: ids 0..7,0 on consecutive edges.
    rst_n = 1'b1;
    #1;
    for (int j = 0; j < 9; j++) begin
      chk($sformatf("rr_ready_%0d", j), 32'(ready_out), 32'(1 << (j % 8)));
      tick();
      chk($sformatf("rr_id_%0d", j), 32'(id_out), 32'(j % 8));
      chk($sformatf("rr_valid_%0d", j), 32'(valid_out), 32'h1);
      chk($sformatf("rr_data_%0d", j), data_out, word(j % 8));
    end

    // Backpressure for 5 cycles: no grants and the held word stays stable.
    ready_in = 1'b0;
    #1;
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("bp_ready_%0d", j), 32'(ready_out), 32'h0);
      tick();
      chk($sformatf("bp_id_%0d", j), 32'(id_out), 32'h0);
      chk($sformatf("bp_data_%0d", j), data_out, word(0));
      chk($sformatf("bp_valid_%0d", j), 32'(valid_out), 32'h1);
    end
    ready_in = 1'b1;
    #1;
    chk("bp_rel_ready", 32'(ready_out), 32'h02);
    tick();
    chk("bp_rel_id", 32'(id_out), 32'h1);

    // Move the pointer to 2, then request channels 5 and 2.
    valid_in = 8'b0000_0100;
    #1;
    chk("p2_ready", 32'(ready_out), 32'h04);
    tick();
    chk("p2_id", 32'(id_out), 32'h2);
    valid_in = 8'b0010_0100;
    #1;
    chk("v24_ready_a", 32'(ready_out), 32'h20);
    tick();
    chk("v24_id_a", 32'(id_out), 32'h5);
    chk("v24_ready_b", 32'(ready_out), 32'h04);
    tick();
    chk("v24_id_b", 32'(id_out), 32'h2);

    // Channel 6 drops its request before being granted; the arbiter skips it.
    valid_in = 8'b0100_0001;
    #1;
    chk("drop_ready_a", 32'(ready_out), 32'h40);
    valid_in = 8'b0000_0001;
    #1;
    chk("drop_ready_b", 32'(ready_out), 32'h01);
    tick();
    chk("drop_id", 32'(id_out), 32'h0);
    valid_in = 8'b0100_0000;
    #1;
    chk("ch6_ready", 32'(ready_out), 32'h40);
    tick();
    chk("ch6_id", 32'(id_out), 32'h6);

    // Drain with no requests: valid drops, data and id hold.
    valid_in = '0;
    #1;
    chk("idle_ready", 32'(ready_out), 32'h0);
    tick();
    chk("idle_valid", 32'(valid_out), 32'h0);
    chk("idle_id", 32'(id_out), 32'h6);
    chk("idle_data", data_out, word(6));

    // Single persistent requester on channel 3: one word per cycle.
    valid_in = 8'b0000_1000;
    for (int k = 0; k < 3; k++) begin
      data_in[3*DW +: DW] = 32'hDEAD_BEEF + 32'(k);
      #1;
      chk($sformatf("ch3_ready_%0d", k), 32'(ready_out), 32'h08);
      tick();
      chk($sformatf("ch3_data_%0d", k), data_out, 32'hDEAD_BEEF + 32'(k));
      chk($sformatf("ch3_id_%0d", k), 32'(id_out), 32'h3);
      chk($sformatf("ch3_valid_%0d", k), 32'(valid_out), 32'h1);
    end

    // Mid-stream reset discards the held word; the first grant after it is channel 0.
    valid_in = 8'hFF;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(valid_out), 32'h0);
    chk("mrst_data", data_out, 32'h0);
    chk("mrst_ready", 32'(ready_out), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("mrst_rel_ready", 32'(ready_out), 32'h01);
    tick();
    chk("mrst_rel_id", 32'(id_out), 32'h0);
    chk("mrst_rel_valid", 32'(valid_out), 32'h1);

    // Channels 4 and 7 requesting: fixed priority always takes 4,
    // while round-robin alternates 4,7,4,7.
    valid_in = 8'b1001_0000;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("fp_ready_%0d", k), 32'(fp_ready_out), 32'h10);
      tick();
      chk($sformatf("fp_id_%0d", k), 32'(fp_id_out), 32'h4);
      chk($sformatf("fp_valid_%0d", k), 32'(fp_valid_out), 32'h1);
      chk($sformatf("rr47_id_%0d", k), 32'(id_out), (k % 2 == 0) ? 32'h4 : 32'h7);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
